zstd_block_parser: RTL and testbench

Sits directly downstream of the frame header parser and consumes the byte stream that follows the frame header. Walks the sequence of 3-byte Zstandard block headers and routes each block's payload to the literals/sequence path. Raw payloads pass through unchanged, RLE blocks are expanded, and Compressed payloads are forwarded untouched for the next stage. After the last block it captures the optional 4-byte content checksum and signals frame completion.

---
 rtl/zstd_block_parser_if.sv | 37 +++
 rtl/zstd_block_parser.sv | 363 ++++++++++++++++++++++++++++++++++++
 tb/tb_zstd_block_parser.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zstd_block_parser_if.sv
// Byte-stream handshake bundle for the Zstandard block parser: input beats in, payload beats out.
// The slave modport is the parser's view; the master modport is the upstream/downstream side.
interface zstd_block_parser_if;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [1:0]  out_keep;
    logic [1:0]  out_type;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  data_in,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_keep,
        output out_type,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport master (
        output data_in,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_keep,
        input  out_type,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/zstd_block_parser.sv
// Walks Zstandard block headers after the frame header, forwards Raw/Compressed payloads,
// expands RLE blocks and captures the optional content checksum.
//
// state      | meaning
// S_IDLE     | waiting for start from the frame header parser
// S_HDR      | collecting the 3-byte block header
// S_RLE_BYTE | collecting the single RLE byte
// S_RLE_EMIT | replicating the RLE byte onto the output
// S_PAYLOAD  | repacking Raw/Compressed payload bytes
// S_NEXT     | block finished, output drained, choose next header/checksum/done
// S_CHK      | collecting the 4-byte content checksum
// S_DONE     | pulse finished
// S_ERROR    | bad header, stalled until reset or start
module zstd_block_parser #(
    parameter int BLOCK_MAX = 131072
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  start_offset,
    input  logic                  checksum_flag,
    zstd_block_parser_if.slave    bus,
    output logic                  hdr_valid,
    output logic                  blk_last,
    output logic [1:0]            blk_type,
    output logic [20:0]           blk_size,
    output logic [31:0]           checksum,
    output logic                  checksum_valid,
    output logic                  finished,
    output logic                  leftover,
    output logic                  error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_RLE_BYTE,
        S_RLE_EMIT,
        S_PAYLOAD,
        S_NEXT,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [21:0] BLK_MAX_L = 22'(BLOCK_MAX);

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] fld_q, fld_d;
    logic [20:0] rem_q, rem_d;
    logic [7:0]  rle_q, rle_d;
    logic        chk_flag_q, chk_flag_d;
    logic [15:0] out_data_q, out_data_d;
    logic [1:0]  out_keep_q, out_keep_d;
    logic [1:0]  out_type_q, out_type_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic        blk_last_q, blk_last_d;
    logic [1:0]  blk_type_q, blk_type_d;
    logic [20:0] blk_size_q, blk_size_d;
    logic [31:0] checksum_q, checksum_d;
    logic        checksum_valid_q, checksum_valid_d;
    logic        finished_q, finished_d;
    logic        leftover_q, leftover_d;
    logic        error_q, error_d;

    logic        out_free;
    logic        in_ready_c;
    logic [2:0]  target;
    logic [2:0]  want;
    logic [1:0]  n_take;
    logic [7:0]  t0, t1;
    logic [2:0]  cnt_new;
    logic        fld_done;
    logic [20:0] hdr_size;
    logic [1:0]  hdr_type;
    logic        emit;
    logic [15:0] emit_data;
    logic [1:0]  emit_keep;
    logic [20:0] emit_dec;

    always_comb begin
        state_d          = state_q;
        hold_d           = hold_q;
        hold_vld_d       = hold_vld_q;
        cnt_d            = cnt_q;
        fld_d            = fld_q;
        rem_d            = rem_q;
        rle_d            = rle_q;
        chk_flag_d       = chk_flag_q;
        out_data_d       = out_data_q;
        out_keep_d       = out_keep_q;
        out_type_d       = out_type_q;
        out_last_d       = out_last_q;
        out_valid_d      = out_valid_q && !bus.out_ready;
        hdr_valid_d      = 1'b0;
        blk_last_d       = blk_last_q;
        blk_type_d       = blk_type_q;
        blk_size_d       = blk_size_q;
        checksum_d       = checksum_q;
        checksum_valid_d = 1'b0;
        finished_d       = 1'b0;
        leftover_d       = 1'b0;
        error_d          = error_q;
        n_take           = 2'd0;
        t0               = 8'h00;
        t1               = 8'h00;
        cnt_new          = cnt_q;
        fld_done         = 1'b0;
        emit             = 1'b0;
        emit_data        = 16'h0000;
        emit_keep        = 2'b00;
        emit_dec         = 21'd0;
        out_free         = !out_valid_q || bus.out_ready;

        case (state_q)
            S_HDR:      target = 3'd3;
            S_CHK:      target = 3'd4;
            S_RLE_BYTE: target = 3'd1;
            default:    target = 3'd0;
        endcase
        want = target - cnt_q;

        // A beat may only be taken if at most one of its bytes is left for the hold register.
        case (state_q)
            S_IDLE, S_ERROR:         in_ready_c = start && start_offset;
            S_HDR, S_CHK, S_RLE_BYTE: in_ready_c = hold_vld_q ? (want >= 3'd2) : 1'b1;
            S_PAYLOAD:               in_ready_c = out_free && (hold_vld_q ? (rem_q >= 21'd2) : 1'b1);
            default:                 in_ready_c = 1'b0;
        endcase

        if (target != 3'd0) begin
            if (hold_vld_q) begin
                t0 = hold_q;
                if (want >= 3'd2 && bus.in_valid) begin
                    n_take = 2'd2;
                    t1     = bus.data_in[15:8];
                    hold_d = bus.data_in[7:0];
                end else begin
                    n_take     = 2'd1;
                    hold_vld_d = 1'b0;
                end
            end else if (bus.in_valid) begin
                t0 = bus.data_in[15:8];
                if (want >= 3'd2) begin
                    n_take = 2'd2;
                    t1     = bus.data_in[7:0];
                end else begin
                    n_take     = 2'd1;
                    hold_d     = bus.data_in[7:0];
                    hold_vld_d = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (n_take != 2'd0 && cnt_q == 3'(i))
                    fld_d[i*8 +: 8] = t0;
                if (n_take == 2'd2 && (cnt_q + 3'd1) == 3'(i))
                    fld_d[i*8 +: 8] = t1;
            end
            cnt_new  = cnt_q + {1'b0, n_take};
            fld_done = (cnt_new == target);
            cnt_d    = fld_done ? 3'd0 : cnt_new;
        end

        hdr_size = fld_d[23:3];
        hdr_type = fld_d[2:1];

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d    = S_HDR;
                    error_d    = 1'b0;
                    chk_flag_d = checksum_flag;
                    cnt_d      = 3'd0;
                    hold_vld_d = start_offset;
                    hold_d     = bus.data_in[7:0];
                end
            end
            S_HDR: begin
                if (fld_done) begin
                    if (hdr_type == 2'd3 || {1'b0, hdr_size} > BLK_MAX_L) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        hdr_valid_d = 1'b1;
                        blk_last_d  = fld_d[0];
                        blk_type_d  = hdr_type;
                        blk_size_d  = hdr_size;
                        rem_d       = hdr_size;
                        if (hdr_size == 21'd0)
                            state_d = S_NEXT;
                        else if (hdr_type == 2'd1)
                            state_d = S_RLE_BYTE;
                        else
                            state_d = S_PAYLOAD;
                    end
                end
            end
            S_RLE_BYTE: begin
                if (fld_done) begin
                    rle_d   = fld_d[7:0];
                    state_d = S_RLE_EMIT;
                end
            end
            S_RLE_EMIT: begin
                if (out_free) begin
                    emit = 1'b1;
                    if (rem_q >= 21'd2) begin
                        emit_data = {rle_q, rle_q};
                        emit_keep = 2'b11;
                        emit_dec  = 21'd2;
                    end else begin
                        emit_data = {rle_q, 8'h00};
                        emit_keep = 2'b10;
                        emit_dec  = 21'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                // Only a block's final beat may be half full, so wait for a full pair otherwise.
                if (out_free) begin
                    if (hold_vld_q) begin
                        if (rem_q == 21'd1) begin
                            emit       = 1'b1;
                            emit_data  = {hold_q, 8'h00};
                            emit_keep  = 2'b10;
                            emit_dec   = 21'd1;
                            hold_vld_d = 1'b0;
                        end else if (bus.in_valid) begin
                            emit      = 1'b1;
                            emit_data = {hold_q, bus.data_in[15:8]};
                            emit_keep = 2'b11;
                            emit_dec  = 21'd2;
                            hold_d    = bus.data_in[7:0];
                        end
                    end else if (bus.in_valid) begin
                        emit = 1'b1;
                        if (rem_q == 21'd1) begin
                            emit_data  = {bus.data_in[15:8], 8'h00};
                            emit_keep  = 2'b10;
                            emit_dec   = 21'd1;
                            hold_d     = bus.data_in[7:0];
                            hold_vld_d = 1'b1;
                        end else begin
                            emit_data = bus.data_in;
                            emit_keep = 2'b11;
                            emit_dec  = 21'd2;
                        end
                    end
                end
            end
            S_NEXT: begin
                if (out_free) begin
                    if (!blk_last_q) begin
                        state_d = S_HDR;
                        cnt_d   = 3'd0;
                    end else if (chk_flag_q) begin
                        state_d = S_CHK;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CHK: begin
                if (fld_done) begin
                    checksum_d       = fld_d;
                    checksum_valid_d = 1'b1;
                    state_d          = S_DONE;
                end
            end
            S_DONE: begin
                finished_d = 1'b1;
                leftover_d = hold_vld_q;
                hold_vld_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_data;
            out_keep_d  = emit_keep;
            out_type_d  = blk_type_q;
            rem_d       = rem_q - emit_dec;
            out_last_d  = (rem_d == 21'd0);
            if (rem_d == 21'd0)
                state_d = S_NEXT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            hold_q           <= 8'h00;
            hold_vld_q       <= 1'b0;
            cnt_q            <= 3'd0;
            fld_q            <= 32'h0;
            rem_q            <= 21'd0;
            rle_q            <= 8'h00;
            chk_flag_q       <= 1'b0;
            out_data_q       <= 16'h0000;
            out_keep_q       <= 2'b00;
            out_type_q       <= 2'b00;
            out_last_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            hdr_valid_q      <= 1'b0;
            blk_last_q       <= 1'b0;
            blk_type_q       <= 2'b00;
            blk_size_q       <= 21'd0;
            checksum_q       <= 32'h0;
            checksum_valid_q <= 1'b0;
            finished_q       <= 1'b0;
            leftover_q       <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            hold_q           <= hold_d;
            hold_vld_q       <= hold_vld_d;
            cnt_q            <= cnt_d;
            fld_q            <= fld_d;
            rem_q            <= rem_d;
            rle_q            <= rle_d;
            chk_flag_q       <= chk_flag_d;
            out_data_q       <= out_data_d;
            out_keep_q       <= out_keep_d;
            out_type_q       <= out_type_d;
            out_last_q       <= out_last_d;
            out_valid_q      <= out_valid_d;
            hdr_valid_q      <= hdr_valid_d;
            blk_last_q       <= blk_last_d;
            blk_type_q       <= blk_type_d;
            blk_size_q       <= blk_size_d;
            checksum_q       <= checksum_d;
            checksum_valid_q <= checksum_valid_d;
            finished_q       <= finished_d;
            leftover_q       <= leftover_d;
            error_q          <= error_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_data    = out_data_q;
    assign bus.out_keep    = out_keep_q;
    assign bus.out_type    = out_type_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_valid   = out_valid_q;
    assign hdr_valid       = hdr_valid_q;
    assign blk_last        = blk_last_q;
    assign blk_type        = blk_type_q;
    assign blk_size        = blk_size_q;
    assign checksum        = checksum_q;
    assign checksum_valid  = checksum_valid_q;
    assign finished        = finished_q;
    assign leftover        = leftover_q;
    assign error           = error_q;

endmodule

// File: tb/tb_zstd_block_parser.sv
// Directed bench for zstd_block_parser: expected beats/headers/checksums are queued as
// stimulus is driven and compared by a monitor when the parser produces them.
module tb_zstd_block_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start_offset = 1'b0;
    logic        checksum_flag = 1'b0;
    logic        hdr_valid, blk_last;
    logic [1:0]  blk_type;
    logic [20:0] blk_size;
    logic [31:0] checksum;
    logic        checksum_valid, finished, leftover, error;

    zstd_block_parser_if bus_if();

    zstd_block_parser #(.BLOCK_MAX(131072)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_offset   (start_offset),
        .checksum_flag  (checksum_flag),
        .bus            (bus_if),
        .hdr_valid      (hdr_valid),
        .blk_last       (blk_last),
        .blk_type       (blk_type),
        .blk_size       (blk_size),
        .checksum       (checksum),
        .checksum_valid (checksum_valid),
        .finished       (finished),
        .leftover       (leftover),
        .error          (error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int chk_cyc = -100;
    logic toggle_en = 1'b0;

    logic [20:0] exp_beats[$];
    logic [23:0] exp_hdr[$];
    logic [31:0] exp_chk[$];
    logic [1:0]  exp_fin[$];

    logic [20:0] mon_obs;
    logic [20:0] held_val;
    logic        held_pend = 1'b0;
    logic [1:0]  fin_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] mk(input logic [1:0] t, input logic [1:0] k, input logic l,
                                       input logic [7:0] hi, input logic [7:0] lo);
        return {t, k, l, hi, lo};
    endfunction

    // Output/event monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            mon_obs = {bus_if.out_type, bus_if.out_keep, bus_if.out_last, bus_if.out_data[15:8],
                       bus_if.out_keep[0] ? bus_if.out_data[7:0] : 8'h00};
            if (held_pend)
                check("out_hold_stable", {bus_if.out_valid, mon_obs}, {1'b1, held_val});
            held_pend = bus_if.out_valid && !bus_if.out_ready;
            held_val  = mon_obs;
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_beats.size() == 0)
                    check("out_beat_unexpected", {43'd0, mon_obs}, 64'd0);
                else
                    check("out_beat", {43'd0, mon_obs}, {43'd0, exp_beats.pop_front()});
            end
            if (bus_if.out_valid && bus_if.out_type == 2'd1)
                check("rle_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
            if (hdr_valid) begin
                if (exp_hdr.size() == 0)
                    check("hdr_unexpected_count", exp_hdr.size(), 1);
                else
                    check("hdr_fields", {blk_last, blk_type, blk_size}, exp_hdr.pop_front());
            end
            if (checksum_valid) begin
                chk_cyc = cyc;
                if (exp_chk.size() == 0)
                    check("chk_unexpected_count", exp_chk.size(), 1);
                else
                    check("checksum", checksum, exp_chk.pop_front());
            end
            if (finished) begin
                if (exp_fin.size() == 0)
                    check("fin_unexpected_count", exp_fin.size(), 1);
                else begin
                    fin_e = exp_fin.pop_front();
                    check("leftover", {63'd0, leftover}, {63'd0, fin_e[0]});
                    if (fin_e[1])
                        check("fin_after_chk", cyc - chk_cyc, 1);
                end
            end
        end else begin
            held_pend = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (toggle_en) bus_if.out_ready = ~bus_if.out_ready;
    end

    task automatic pulse_start(input logic off, input logic flag, input logic [15:0] beat);
        start         = 1'b1;
        start_offset  = off;
        checksum_flag = flag;
        bus_if.data_in  = beat;
        bus_if.in_valid = off;
        @(posedge clk);
        #1;
        start           = 1'b0;
        start_offset    = 1'b0;
        checksum_flag   = 1'b0;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] b);
        logic acc;
        acc = 1'b0;
        bus_if.data_in  = b;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = bus_if.in_ready;
            @(posedge clk);
            #1;
        end
        bus_if.in_valid = 1'b0;
        if (!acc)
            check("in_accept_timeout", {63'd0, acc}, 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_beats.size() == 0 && exp_hdr.size() == 0 && exp_chk.size() == 0 && exp_fin.size() == 0)
                break;
            @(posedge clk);
            #1;
        end
        check("drain_beats", exp_beats.size(), 0);
        check("drain_events", exp_hdr.size() + exp_chk.size() + exp_fin.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        check({tag, "_fields"}, {blk_last, blk_type, blk_size, checksum}, 64'd0);
        check({tag, "_flags"}, {hdr_valid, checksum_valid, finished, leftover, error,
                               bus_if.out_valid, bus_if.out_last, bus_if.in_ready}, 64'd0);
        check({tag, "_out"}, {bus_if.out_data, bus_if.out_keep, bus_if.out_type}, 64'd0);
    endtask

    initial begin
        bus_if.data_in   = 16'h0000;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Aligned raw last block, size 5
        exp_hdr.push_back({1'b1, 2'd0, 21'd5});
        exp_beats.push_back(mk(2'd0, 2'b11, 1'b0, 8'hA1, 8'hA2));
        exp_beats.push_back(mk(2'd0, 2'b11, 1'b0, 8'hA3, 8'hA4));
        exp_beats.push_back(mk(2'd0, 2'b10, 1'b1, 8'hA5, 8'h00));
        exp_fin.push_back(2'b00);
        pulse_start(1'b0, 1'b0, 16'h0000);
        send_beat(16'h2900);
        send_beat(16'h00A1);
        send_beat(16'hA2A3);
        send_beat(16'hA4A5);
        wait_drain();

        // RLE block with start_offset, followed by an empty last raw block
        exp_hdr.push_back({1'b0, 2'd1, 21'd4});
        exp_hdr.push_back({1'b1, 2'd0, 21'd0});
        exp_beats.push_back(mk(2'd1, 2'b11, 1'b0, 8'hBB, 8'hBB));
        exp_beats.push_back(mk(2'd1, 2'b11, 1'b1, 8'hBB, 8'hBB));
        exp_fin.push_back(2'b00);
        pulse_start(1'b1, 1'b0, 16'hEE22);
        send_beat(16'h0000);
        send_beat(16'hBB01);
        send_beat(16'h0000);
        wait_drain();

        // Reserved block type
        pulse_start(1'b0, 1'b0, 16'h0000);
        send_beat(16'h0600);
        send_beat(16'h00EE);
        bus_if.data_in  = 16'h5555;
        bus_if.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reserved_error", {63'd0, error}, 64'd1);
        check("reserved_in_ready", {62'd0, bus_if.in_ready, bus_if.out_valid}, 64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("error_sticky", {63'd0, error}, 64'd1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        pulse_start(1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check("error_cleared_by_start", {63'd0, error}, 64'd0);
        @(posedge clk);
        #1;

        // Oversize block
        send_beat(16'hF8FF);
        send_beat(16'hFF00);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("oversize_error", {63'd0, error}, 64'd1);
        check("oversize_no_out", {63'd0, bus_if.out_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Empty last block with content checksum
        exp_hdr.push_back({1'b1, 2'd0, 21'd0});
        exp_chk.push_back(32'h12345678);
        exp_fin.push_back(2'b11);
        pulse_start(1'b0, 1'b1, 16'h0000);
        send_beat(16'h0100);
        send_beat(16'h0078);
        send_beat(16'h5634);
        send_beat(16'h12CC);
        wait_drain();
        check("chk_error_clear", {63'd0, error}, 64'd0);

        // 9-byte raw block under toggling backpressure
        exp_hdr.push_back({1'b1, 2'd0, 21'd9});
        exp_beats.push_back(mk(2'd0, 2'b11, 1'b0, 8'hD0, 8'hD1));
        exp_beats.push_back(mk(2'd0, 2'b11, 1'b0, 8'hD2, 8'hD3));
        exp_beats.push_back(mk(2'd0, 2'b11, 1'b0, 8'hD4, 8'hD5));
        exp_beats.push_back(mk(2'd0, 2'b11, 1'b0, 8'hD6, 8'hD7));
        exp_beats.push_back(mk(2'd0, 2'b10, 1'b1, 8'hD8, 8'h00));
        exp_fin.push_back(2'b00);
        pulse_start(1'b0, 1'b0, 16'h0000);
        toggle_en = 1'b1;
        send_beat(16'h4900);
        send_beat(16'h00D0);
        send_beat(16'hD1D2);
        send_beat(16'hD3D4);
        send_beat(16'hD5D6);
        send_beat(16'hD7D8);
        wait_drain();
        toggle_en = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset low in the middle of a stalled payload
        bus_if.out_ready = 1'b0;
        exp_hdr.push_back({1'b1, 2'd0, 21'd9});
        pulse_start(1'b0, 1'b0, 16'h0000);
        send_beat(16'h4900);
        send_beat(16'h00D0);
        send_beat(16'hD1D2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midblock_out_valid", {63'd0, bus_if.out_valid}, 64'd1);
        check("midblock_hdr_seen", exp_hdr.size(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("midblock_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Fresh frame after reset: offset start, 2-byte raw block
        exp_hdr.push_back({1'b1, 2'd0, 21'd2});
        exp_beats.push_back(mk(2'd0, 2'b11, 1'b1, 8'hE0, 8'hE1));
        exp_fin.push_back(2'b00);
        pulse_start(1'b1, 1'b0, 16'hEE11);
        send_beat(16'h0000);
        send_beat(16'hE0E1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
